// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues word fetches on the instruction bus
// and buffers returned words in a 2-entry queue feeding IF/ID.
module if_fetch #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        ex_jump_en_i,
    input  logic [31:0] ex_jump_addr_i,
    input  logic        prd_jump_en_i,
    input  logic [31:0] prd_jump_base_i,
    input  logic [31:0] prd_jump_ofset_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] instaddr_o
);

    logic [31:0] pc;
    logic [31:0] req_addr;
    logic        started;
    logic        outstanding;
    logic        kill;

    logic [31:0] fifo_addr [2];
    logic [31:0] fifo_inst [2];
    logic        rptr;
    logic        wptr;
    logic [1:0]  count;

    logic        prd_take;
    logic        redirect;
    logic [31:0] prd_sum;
    logic [31:0] target;
    logic        rsp;
    logic        push;
    logic        pop;
    logic        grant;
    logic [2:0]  occupancy;

    always_comb begin
        prd_take     = prd_jump_en_i && !stall_i;
        redirect     = ex_jump_en_i || prd_take;
        prd_sum      = prd_jump_base_i + prd_jump_ofset_i;
        target       = ex_jump_en_i ? ex_jump_addr_i : {prd_sum[31:1], 1'b0};
        rsp          = outstanding && ibus_rvalid_i;
        push         = rsp && !kill && !redirect;
        inst_valid_o = (count != 2'd0) && !redirect;
        pop          = inst_valid_o && !stall_i;
        // Queue slots after this cycle's pop, counting a live in-flight word as already queued
        occupancy    = {1'b0, count} - {2'b00, pop} + {2'b00, outstanding && !kill};
        ibus_req_o   = started && !redirect && (!outstanding || ibus_rvalid_i)
                       && (occupancy < 3'd2);
        grant        = ibus_req_o && ibus_gnt_i;
    end

    assign ibus_addr_o = pc;
    assign inst_o      = inst_valid_o ? fifo_inst[rptr] : NOP_INST;
    assign instaddr_o  = inst_valid_o ? fifo_addr[rptr] : RESET_ADDR;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc          <= RESET_ADDR;
            started     <= 1'b0;
            outstanding <= 1'b0;
            kill        <= 1'b0;
            rptr        <= 1'b0;
            wptr        <= 1'b0;
            count       <= 2'd0;
        end else begin
            started <= 1'b1;

            if (redirect)
                pc <= target;
            else if (grant)
                pc <= pc + 32'd4;

            if (grant)
                outstanding <= 1'b1;
            else if (rsp)
                outstanding <= 1'b0;

            // A wrong-path word still on the bus must be swallowed when it returns
            if (redirect && outstanding && !ibus_rvalid_i)
                kill <= 1'b1;
            else if (rsp)
                kill <= 1'b0;

            if (redirect) begin
                rptr  <= 1'b0;
                wptr  <= 1'b0;
                count <= 2'd0;
            end else begin
                if (push)
                    wptr <= ~wptr;
                if (pop)
                    rptr <= ~rptr;
                count <= count + {1'b0, push} - {1'b0, pop};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant)
            req_addr <= pc;
        if (push) begin
            fifo_addr[wptr] <= req_addr;
            fifo_inst[wptr] <= ibus_rdata_i;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: always-grant bus with responses one cycle after grant,
// expected addresses hand-computed per cycle.
module tb_if_fetch;

    logic        clk;
    logic        rst;
    logic        stall_i;
    logic        ex_jump_en_i;
    logic [31:0] ex_jump_addr_i;
    logic        prd_jump_en_i;
    logic [31:0] prd_jump_base_i;
    logic [31:0] prd_jump_ofset_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] instaddr_o;

    int checks = 0;
    int errors = 0;

    logic        pend;
    logic [31:0] pend_addr;
    logic        hold_rv;
    logic        seen108;
    logic        s_req;
    logic [31:0] s_addr;
    logic        s_valid;
    logic [31:0] s_iaddr;
    logic [31:0] s_inst;

    if_fetch #(
        .RESET_ADDR(32'h0000_0000),
        .NOP_INST  (32'h0000_0013)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .ex_jump_en_i    (ex_jump_en_i),
        .ex_jump_addr_i  (ex_jump_addr_i),
        .prd_jump_en_i   (prd_jump_en_i),
        .prd_jump_base_i (prd_jump_base_i),
        .prd_jump_ofset_i(prd_jump_ofset_i),
        .ibus_req_o      (ibus_req_o),
        .ibus_addr_o     (ibus_addr_o),
        .ibus_gnt_i      (ibus_gnt_i),
        .ibus_rvalid_i   (ibus_rvalid_i),
        .ibus_rdata_i    (ibus_rdata_i),
        .inst_valid_o    (inst_valid_o),
        .inst_o          (inst_o),
        .instaddr_o      (instaddr_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One bus cycle: drive the response, sample outputs mid-cycle, then cross the edge
    task automatic cyc();
        logic        did_grant;
        logic [31:0] gaddr;
        ibus_rvalid_i = pend && !hold_rv;
        ibus_rdata_i  = pend_addr + 32'h1000_0000;
        #1;
        s_req     = ibus_req_o;
        s_addr    = ibus_addr_o;
        s_valid   = inst_valid_o;
        s_iaddr   = instaddr_o;
        s_inst    = inst_o;
        did_grant = ibus_req_o && ibus_gnt_i;
        gaddr     = ibus_addr_o;
        if (did_grant && gaddr == 32'h108)
            seen108 = 1'b1;
        @(posedge clk);
        if (did_grant) begin
            pend      = 1'b1;
            pend_addr = gaddr;
        end else if (ibus_rvalid_i) begin
            pend = 1'b0;
        end
        #1;
    endtask

    initial begin
        rst              = 1'b1;
        stall_i          = 1'b0;
        ex_jump_en_i     = 1'b0;
        ex_jump_addr_i   = 32'h0;
        prd_jump_en_i    = 1'b0;
        prd_jump_base_i  = 32'h0;
        prd_jump_ofset_i = 32'h0;
        ibus_gnt_i       = 1'b1;
        ibus_rvalid_i    = 1'b0;
        ibus_rdata_i     = 32'h0;
        pend             = 1'b0;
        pend_addr        = 32'h0;
        hold_rv          = 1'b0;
        seen108          = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req",   {31'b0, ibus_req_o},   32'h0);
        check("rst_addr",  ibus_addr_o,           32'h0);
        check("rst_vld",   {31'b0, inst_valid_o}, 32'h0);
        check("rst_inst",  inst_o,                32'h13);
        check("rst_iaddr", instaddr_o,            32'h0);
        rst = 1'b0;

        // sequential fetch
        cyc(); check("c0_req",  {31'b0, s_req},   32'h0);
        cyc(); check("c1_req",  {31'b0, s_req},   32'h1);
               check("c1_addr", s_addr,           32'h0);
               check("c1_vld",  {31'b0, s_valid}, 32'h0);
        cyc(); check("c2_addr", s_addr,           32'h4);
               check("c2_vld",  {31'b0, s_valid}, 32'h0);
        cyc(); check("c3_vld",  {31'b0, s_valid}, 32'h1);
               check("c3_iaddr", s_iaddr,         32'h0);
               check("c3_inst", s_inst,           32'h1000_0000);
               check("c3_addr", s_addr,           32'h8);
        cyc(); check("c4_iaddr", s_iaddr,         32'h4);
               check("c4_addr", s_addr,           32'hC);
        cyc(); check("c5_iaddr", s_iaddr,         32'h8);
               check("c5_addr", s_addr,           32'h10);

        // stall fill
        stall_i = 1'b1;
        cyc(); check("st0_iaddr", s_iaddr,        32'hC);
               check("st0_req", {31'b0, s_req},   32'h0);
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("st_req",   {31'b0, s_req},   32'h0);
            check("st_pc",    s_addr,           32'h14);
            check("st_iaddr", s_iaddr,          32'hC);
            check("st_vld",   {31'b0, s_valid}, 32'h1);
        end
        stall_i = 1'b0;
        cyc(); check("rs0_iaddr", s_iaddr,        32'hC);
               check("rs0_req", {31'b0, s_req},   32'h1);
               check("rs0_addr", s_addr,          32'h14);
        cyc(); check("rs1_iaddr", s_iaddr,        32'h10);
        cyc(); check("rs2_iaddr", s_iaddr,        32'h14);

        // predicted jump with the response delayed past the redirect
        prd_jump_en_i    = 1'b1;
        prd_jump_base_i  = 32'h100;
        prd_jump_ofset_i = 32'hFFFF_FFF0;
        hold_rv          = 1'b1;
        cyc(); check("pj_vld", {31'b0, s_valid},  32'h0);
               check("pj_req", {31'b0, s_req},    32'h0);
        prd_jump_en_i = 1'b0;
        hold_rv       = 1'b0;
        cyc(); check("pj1_req", {31'b0, s_req},   32'h1);
               check("pj1_addr", s_addr,          32'hF0);
               check("pj1_vld", {31'b0, s_valid}, 32'h0);
        cyc(); check("pj2_vld", {31'b0, s_valid}, 32'h0);
        cyc(); check("pj3_vld", {31'b0, s_valid}, 32'h1);
               check("pj3_iaddr", s_iaddr,        32'hF0);
        cyc(); check("pj4_iaddr", s_iaddr,        32'hF4);

        // EX redirect beats prediction
        ex_jump_en_i     = 1'b1;
        ex_jump_addr_i   = 32'h200;
        prd_jump_en_i    = 1'b1;
        prd_jump_base_i  = 32'h100;
        prd_jump_ofset_i = 32'h8;
        cyc(); check("pr_req", {31'b0, s_req},    32'h0);
               check("pr_vld", {31'b0, s_valid},  32'h0);
        ex_jump_en_i  = 1'b0;
        prd_jump_en_i = 1'b0;
        cyc(); check("pr1_addr", s_addr,          32'h200);
               check("pr1_req", {31'b0, s_req},   32'h1);
        cyc(); check("pr2_addr", s_addr,          32'h204);
        cyc(); check("pr3_iaddr", s_iaddr,        32'h200);

        // prediction held off by stall
        stall_i          = 1'b1;
        prd_jump_en_i    = 1'b1;
        prd_jump_base_i  = 32'h300;
        prd_jump_ofset_i = 32'h10;
        cyc(); check("sp0_vld", {31'b0, s_valid}, 32'h1);
               check("sp0_iaddr", s_iaddr,        32'h204);
               check("sp0_req", {31'b0, s_req},   32'h0);
        cyc(); check("sp1_pc", s_addr,            32'h20C);
               check("sp1_vld", {31'b0, s_valid}, 32'h1);
        cyc(); check("sp2_pc", s_addr,            32'h20C);
               check("sp2_iaddr", s_iaddr,        32'h204);
        stall_i = 1'b0;
        cyc(); check("sp3_vld", {31'b0, s_valid}, 32'h0);
               check("sp3_req", {31'b0, s_req},   32'h0);
        prd_jump_en_i = 1'b0;
        cyc(); check("sp4_addr", s_addr,          32'h310);
               check("sp4_req", {31'b0, s_req},   32'h1);

        // JALR alignment and wrap
        prd_jump_en_i    = 1'b1;
        prd_jump_base_i  = 32'hFFFF_FFFD;
        prd_jump_ofset_i = 32'h4;
        cyc(); check("wr_req", {31'b0, s_req},    32'h0);
        prd_jump_en_i = 1'b0;
        cyc(); check("wr_addr", s_addr,           32'h0);
               check("wr_req1", {31'b0, s_req},   32'h1);

        // asynchronous reset mid-fetch, then a stale response after release
        #2;
        rst = 1'b1;
        #1;
        check("mr_req",   {31'b0, ibus_req_o},   32'h0);
        check("mr_addr",  ibus_addr_o,           32'h0);
        check("mr_vld",   {31'b0, inst_valid_o}, 32'h0);
        check("mr_inst",  inst_o,                32'h13);
        check("mr_iaddr", instaddr_o,            32'h0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        pend      = 1'b1;
        pend_addr = 32'h55;
        cyc(); check("mr0_req", {31'b0, s_req},   32'h0);
               check("mr0_vld", {31'b0, s_valid}, 32'h0);
        cyc(); check("mr1_req", {31'b0, s_req},   32'h1);
               check("mr1_addr", s_addr,          32'h0);
        cyc(); check("mr2_vld", {31'b0, s_valid}, 32'h0);
        cyc(); check("mr3_vld", {31'b0, s_valid}, 32'h1);
               check("mr3_iaddr", s_iaddr,        32'h0);
               check("mr3_inst", s_inst,          32'h1000_0000);

        check("no_fetch_108", {31'b0, seen108}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage that owns the program counter and feeds the IF/ID register. It consumes the static branch prediction (jump enable, base, offset) produced from the instruction held in IF/ID, and the misprediction correction from EX. It issues word fetches on a request/grant/rvalid instruction bus and buffers returned instructions in a 2-entry queue. On every redirect it kills wrong-path fetches.

## Interface
- `RESET_ADDR`, 32'h0000_0000: PC value after reset.
- `NOP_INST`, 32'h0000_0013: value driven on `inst_o` when no valid instruction is available.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `stall_i` in 1: from ctrl; IF/ID holds its contents and no instruction is popped.
- `ex_jump_en_i` in 1: EX branch/jump resolution disagrees with the prediction; redirect required.
- `ex_jump_addr_i` in 32: correct target from EX.
- `prd_jump_en_i` in 1: predicted-taken from the prediction unit.
- `prd_jump_base_i` in 32: prediction base (instruction address or forwarded rs1).
- `prd_jump_ofset_i` in 32: sign-extended prediction offset.
- `ibus_req_o` out 1: fetch request.
- `ibus_addr_o` out 32: fetch address; always equals the PC register.
- `ibus_gnt_i` in 1: request accepted this cycle.
- `ibus_rvalid_i` in 1: read data valid for the oldest outstanding request.
- `ibus_rdata_i` in 32: fetched instruction word.
- `inst_valid_o` out 1: `inst_o` and `instaddr_o` are valid for IF/ID.
- `inst_o` out 32: instruction at the queue head, or `NOP_INST`.
- `instaddr_o` out 32: address of `inst_o`, or `RESET_ADDR` when invalid.

## Operation
- **State:**
  - `pc` (32 bits).
  - `started` flag.
  - `outstanding` (0..1).
  - `kill` flag.
  - `req_addr` (address of the outstanding request).
  - 2-entry FIFO of {addr, inst}, with 1-bit read and write pointers and a 2-bit count.
- **Redirect target, with priority high to low:**
  - If `ex_jump_en_i`: target is `ex_jump_addr_i`.
  - Else if `prd_jump_en_i && !stall_i`: target is `prd_jump_base_i + prd_jump_ofset_i`, a 32-bit add with wrap-around and bit 0 forced to 0.
  - `prd_jump_en_i` is ignored while `stall_i` = 1.
  - `redirect` = either of the two conditions above.
- **On redirect:**
  - `pc` <= target.
  - FIFO cleared: count 0, pointers 0.
  - `ibus_req_o` = 0 in that cycle.
  - If `outstanding`=1 and `ibus_rvalid_i`=0, set `kill`.
  - A response arriving in the redirect cycle is dropped.
  - `inst_valid_o` = 0 in that cycle.
- **Request condition:** `ibus_req_o` = `started && !redirect && (outstanding==0 || ibus_rvalid_i) && (count + outstanding_after_rvalid) < 2`.
  - Space is therefore reserved for every in-flight response.
- **On grant** (`ibus_req_o && ibus_gnt_i`, no redirect):
  - `req_addr` <= `pc`.
  - `pc` <= `pc + 4` (wraps).
  - `outstanding` <= 1.
- **On `ibus_rvalid_i`:**
  - `outstanding` decrements, unless a grant occurs in the same cycle.
  - If `kill`=1: data is discarded and `kill` clears.
  - Else, with no redirect: push {`req_addr`, `ibus_rdata_i`}.
  - `ibus_rvalid_i` with `outstanding`=0 is ignored.
- **Pop:** when `inst_valid_o && !stall_i`.
  - Push and pop in the same cycle leave count unchanged.
- **Output:** `inst_valid_o` = `count != 0 && !redirect`.
- **Reset values:**
  - `pc` = `RESET_ADDR`; `started` = 0; `outstanding` = 0; `kill` = 0; FIFO empty.
  - `ibus_req_o` = 0, `ibus_addr_o` = `RESET_ADDR`.
  - `inst_valid_o` = 0, `inst_o` = `NOP_INST`, `instaddr_o` = `RESET_ADDR`.
- **Reset mid-operation:** all state clears immediately. A response arriving after reset release with `outstanding`=0 is ignored.

## Timing
- `started` sets on the first clock edge after `rst` falls, so `ibus_req_o` first rises one cycle after reset release.
- Grant in cycle N: earliest `ibus_rvalid_i` is N+1, and `inst_valid_o` for that word is N+2. Latency is 2 cycles from grant to IF/ID visibility.
- With grant and rvalid every cycle, throughput is one instruction per cycle and the FIFO holds 1 entry steady-state.
- Redirect in cycle R: `pc` = target in R+1, first request for the target in R+1, first valid instruction no earlier than R+3.
- FIFO full (count 2, stalled): `ibus_req_o` = 0 and `pc` holds.
- `ex_jump_en_i` and `prd_jump_en_i` in the same cycle: the EX target wins, and the prediction is dropped.

## Test plan
- **Reset / sequential fetch.** Release reset with `RESET_ADDR`=0, always-grant, rvalid one cycle later, no stall.
  - Required: `ibus_addr_o` 0,4,8,...
  - Required: `inst_valid_o` first high 3 cycles after release, `instaddr_o` 0,4,8 on consecutive cycles.
- **Stall fill.** Stall=1 for 5 cycles mid-stream.
  - Required: FIFO reaches count 2, `ibus_req_o` drops, and `pc` holds.
  - Required: after stall release, instructions resume in order with no loss or duplication.
- **Predicted jump.** `prd_jump_en_i`=1, base 32'h100, offset 32'hFFFF_FFF0, while one fetch is outstanding.
  - Required: the next `ibus_addr_o` is 32'hF0, the outstanding response is dropped, and the first valid `instaddr_o` is 32'hF0.
- **Priority.** EX redirect to 32'h200 and prediction 32'h100+8 in the same cycle.
  - Required: `ibus_addr_o` becomes 32'h200; 32'h108 is never fetched.
- **Stalled prediction.** `prd_jump_en_i`=1 with `stall_i`=1 for 3 cycles.
  - Required: no redirect during those cycles, and the redirect occurs in the cycle `stall_i` drops.
- **JALR alignment and wrap.** Prediction base 32'hFFFF_FFFD, offset 32'h4.
  - Required: target is 32'h0000_0000 (bit 0 cleared, sum wraps).
  - Required: `rst` pulsed mid-fetch returns all outputs to their reset values asynchronously.
